// File: rtl/multi_channel_ascii_sender.sv
// multi_channel_ascii_sender: formats N channel values of W bits as one ASCII line
// (binary or hex digits, SEP_CHAR between channels, CR LF or LF at the end)
// and writes it one character at a time into the uart_tx6 transmit buffer.
module multi_channel_ascii_sender #(
  parameter int unsigned W        = 18,
  parameter int unsigned N        = 4,
  parameter logic [7:0]  SEP_CHAR = 8'h2C,
  parameter bit          EOL_CRLF = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           send,
  input  logic           mode,
  input  logic [W*N-1:0] values,
  input  logic           tx_full,
  output logic [7:0]     ascii_out,
  output logic           write,
  output logic           busy,
  output logic           done
);

  localparam int unsigned DW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HD = (W + 3) / 4;
  localparam int unsigned PW = 4 * HD;
  localparam logic [DW-1:0] BIN_LAST = DW'(W - 1);
  localparam logic [DW-1:0] HEX_LAST = DW'(HD - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, EMIT, GAP, EOL_CR, EOL_LF, DONE
  } state_t;

  state_t         state_q, state_d;
  state_t         ret_q, ret_d;
  logic [W-1:0]   val_q [N];
  logic           mode_q;
  logic [DW-1:0]  dig_q;
  logic [CW-1:0]  ch_q;
  logic           sep_q;
  logic           emit_now;
  logic [7:0]     cur_char;
  logic [W-1:0]   val_cur;
  logic [PW-1:0]  padded;
  logic [3:0]     nib;

  // Character for the current emit-type state: separator, digit, CR or LF.
  always_comb begin
    val_cur  = val_q[ch_q];
    padded   = PW'(val_cur);
    nib      = padded[{dig_q, 2'b00} +: 4];
    cur_char = '0;
    case (state_q)
      EMIT: begin
        if (sep_q)       cur_char = SEP_CHAR;
        else if (mode_q) cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        else             cur_char = val_cur[dig_q] ? 8'h31 : 8'h30;
      end
      EOL_CR:  cur_char = 8'h0D;
      EOL_LF:  cur_char = 8'h0A;
      default: cur_char = '0;
    endcase
  end

  // Next-state logic; ret_d remembers which emit-type state follows the GAP.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    emit_now = 1'b0;
    case (state_q)
      IDLE: if (send) state_d = EMIT;
      EMIT: if (!tx_full) begin
        emit_now = 1'b1;
        state_d  = GAP;
        if (!sep_q && dig_q == '0 && ch_q == CH_LAST)
          ret_d = EOL_CRLF ? EOL_CR : EOL_LF;
        else
          ret_d = EMIT;
      end
      EOL_CR: if (!tx_full) begin
        emit_now = 1'b1;
        state_d  = GAP;
        ret_d    = EOL_LF;
      end
      EOL_LF: if (!tx_full) begin
        emit_now = 1'b1;
        state_d  = GAP;
        ret_d    = DONE;
      end
      GAP:     state_d = ret_q;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, latched frame data, digit/channel counters and write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      mode_q    <= 1'b0;
      dig_q     <= '0;
      ch_q      <= '0;
      sep_q     <= 1'b0;
      write     <= 1'b0;
      ascii_out <= '0;
      for (int unsigned k = 0; k < N; k++) val_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      write   <= emit_now;
      if (emit_now) ascii_out <= cur_char;
      if (state_q == IDLE && send) begin
        mode_q <= mode;
        dig_q  <= mode ? HEX_LAST : BIN_LAST;
        ch_q   <= '0;
        sep_q  <= 1'b0;
        for (int unsigned k = 0; k < N; k++) val_q[k] <= values[k*W +: W];
      end else if (emit_now && state_q == EMIT) begin
        // A separator advances the channel; the last digit of the last channel leaves counters idle.
        if (sep_q) begin
          sep_q <= 1'b0;
          ch_q  <= ch_q + CW'(1);
          dig_q <= mode_q ? HEX_LAST : BIN_LAST;
        end else if (dig_q == '0) begin
          if (ch_q != CH_LAST) sep_q <= 1'b1;
        end else begin
          dig_q <= dig_q - DW'(1);
        end
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_multi_channel_ascii_sender.sv
// Testbench for multi_channel_ascii_sender: three instances (W=8/N=2, W=18/N=4,
// W=4/N=1 LF-only) checked against hand-computed ASCII lines and timing.
module tb_multi_channel_ascii_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst    [3];
  logic        send   [3];
  logic        mode   [3];
  logic        tx_full[3];
  logic [7:0]  asc    [3];
  logic        wr     [3];
  logic        bz     [3];
  logic        dn     [3];
  logic [15:0] values_a;
  logic [71:0] values_b;
  logic [3:0]  values_c;

  multi_channel_ascii_sender #(.W(8), .N(2), .SEP_CHAR(8'h2C), .EOL_CRLF(1'b1)) dut_a (
    .clk(clk), .reset(rst[0]), .send(send[0]), .mode(mode[0]), .values(values_a),
    .tx_full(tx_full[0]), .ascii_out(asc[0]), .write(wr[0]), .busy(bz[0]), .done(dn[0]));

  multi_channel_ascii_sender #(.W(18), .N(4), .SEP_CHAR(8'h2C), .EOL_CRLF(1'b1)) dut_b (
    .clk(clk), .reset(rst[1]), .send(send[1]), .mode(mode[1]), .values(values_b),
    .tx_full(tx_full[1]), .ascii_out(asc[1]), .write(wr[1]), .busy(bz[1]), .done(dn[1]));

  multi_channel_ascii_sender #(.W(4), .N(1), .SEP_CHAR(8'h2C), .EOL_CRLF(1'b0)) dut_c (
    .clk(clk), .reset(rst[2]), .send(send[2]), .mode(mode[2]), .values(values_c),
    .tx_full(tx_full[2]), .ascii_out(asc[2]), .write(wr[2]), .busy(bz[2]), .done(dn[2]));

  int    checks = 0;
  int    errors = 0;
  string cap      [3];
  int    wr_cnt   [3];
  int    first_wr [3];
  int    done_cyc [3];
  int    t_acc    [3];

  // Capture every written character and the done cycle for each instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr[i]) begin
        cap[i] = $sformatf("%s%c", cap[i], asc[i]);
        wr_cnt[i]++;
        if (first_wr[i] < 0) first_wr[i] = cyc;
      end
      if (dn[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic chks(input string nm, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got \"%s\" want \"%s\"", nm, got, exp);
    end
  endtask

  task automatic start(input int i, input logic m, input logic [71:0] v, input logic hold);
    @(negedge clk);
    cap[i] = ""; wr_cnt[i] = 0; first_wr[i] = -1; done_cyc[i] = -1;
    send[i] = 1'b1; mode[i] = m;
    case (i)
      0: values_a = v[15:0];
      1: values_b = v;
      default: values_c = v[3:0];
    endcase
    @(posedge clk); #1;
    t_acc[i] = cyc;
    if (!hold) send[i] = 1'b0;
  endtask

  task automatic finish_frame(input int i, input string exp, input int stall, input string nm);
    int n = 0;
    int l = exp.len();
    while (done_cyc[i] < 0 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    send[i] = 1'b0;
    if (done_cyc[i] < 0) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chks({nm, "_text"}, cap[i], exp);
      chk({nm, "_first_wr"}, first_wr[i] - t_acc[i], 1);
      chk({nm, "_done_at"}, done_cyc[i] - t_acc[i], 2*l + stall);
      chk({nm, "_busy_at_done"}, int'(bz[i]), 1);
      @(negedge clk); #1;
      chk({nm, "_busy_after"}, int'(bz[i]), 0);
      chk({nm, "_done_pulse"}, int'(dn[i]), 0);
    end
  endtask

  typedef struct {
    logic        m;
    logic [71:0] v;
    string       exp;
  } vec_t;
  vec_t tbl[3];

  initial begin
    tbl[0] = '{m: 1'b1, v: {18'h00001, 18'h12345, 18'h00000, 18'h3FFFF},
               exp: "3FFFF,00000,12345,00001\r\n"};
    tbl[1] = '{m: 1'b1, v: {18'h00009, 18'h0F0F0, 18'h10000, 18'h2ABCD},
               exp: "2ABCD,10000,0F0F0,00009\r\n"};
    tbl[2] = '{m: 1'b0, v: {18'h15555, 18'h3FFFF, 18'h00000, 18'h20001},
               exp: "100000000000000001,000000000000000000,111111111111111111,010101010101010101\r\n"};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; send[i] = 1'b0; mode[i] = 1'b0; tx_full[i] = 1'b0;
      cap[i] = ""; wr_cnt[i] = 0; first_wr[i] = -1; done_cyc[i] = -1; t_acc[i] = 0;
    end
    values_a = '0; values_b = '0; values_c = '0;

    // Reset state, with send asserted during reset on every instance (reset wins).
    @(negedge clk);
    for (int i = 0; i < 3; i++) send[i] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_write", i), int'(wr[i]), 0);
      chk($sformatf("rst%0d_busy", i), int'(bz[i]), 0);
      chk($sformatf("rst%0d_done", i), int'(dn[i]), 0);
      chk($sformatf("rst%0d_ascii", i), int'(asc[i]), 0);
      rst[i] = 1'b0; send[i] = 1'b0;
    end
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) chk($sformatf("rst%0d_no_accept", i), int'(bz[i]), 0);

    // T1: binary, W=8 N=2.
    start(0, 1'b0, 72'h05A3, 1'b0);
    finish_frame(0, "10100011,00000101\r\n", 0, "t1");
    chk("t1_writes", wr_cnt[0], 19);

    // Table-driven frames on the W=18 N=4 instance (row 0 is T2).
    for (int r = 0; r < 3; r++) begin
      start(1, tbl[r].m, tbl[r].v, 1'b0);
      finish_frame(1, tbl[r].exp, 0, $sformatf("vec%0d", r));
      chk($sformatf("vec%0d_writes", r), wr_cnt[1], tbl[r].exp.len());
    end

    // T3: backpressure for 5 cycles in front of the 4th character.
    start(0, 1'b0, 72'h05A3, 1'b0);
    repeat (7) @(negedge clk);
    tx_full[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("t3_hold_write%0d", k), int'(wr[0]), 0);
      chk($sformatf("t3_hold_ascii%0d", k), int'(asc[0]), 8'h31);
    end
    tx_full[0] = 1'b0;
    finish_frame(0, "10100011,00000101\r\n", 5, "t3");

    // T4: send held high for the whole frame including the DONE cycle.
    start(1, tbl[0].m, tbl[0].v, 1'b1);
    finish_frame(1, tbl[0].exp, 0, "t4");
    repeat (10) @(negedge clk);
    #1;
    chk("t4_writes", wr_cnt[1], 25);
    chk("t4_no_restart", int'(bz[1]), 0);

    // T5: reset after the 7th write, then a clean frame.
    start(1, tbl[0].m, tbl[0].v, 1'b0);
    for (int n = 0; n < 100 && wr_cnt[1] < 7; n++) begin
      @(negedge clk); #1;
    end
    chk("t5_reached_7", wr_cnt[1], 7);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("t5_write", int'(wr[1]), 0);
    chk("t5_busy", int'(bz[1]), 0);
    chk("t5_done", int'(dn[1]), 0);
    chk("t5_ascii", int'(asc[1]), 0);
    start(1, tbl[0].m, tbl[0].v, 1'b0);
    finish_frame(1, tbl[0].exp, 0, "t5_after");

    // T6: LF-only, single hex digit.
    start(2, 1'b1, 72'hC, 1'b0);
    finish_frame(2, "C\n", 0, "t6");
    chk("t6_done_at4", done_cyc[2] - t_acc[2], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
